// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Consumers: serial_adder, serial_fa_cell.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Bit counter width; never narrower than one bit even for tiny operands.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder built from two half-adder stages and an OR of their carries.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs0, hc0, hc1;

  always_comb begin
    hs0 = x ^ y;
    hc0 = x & y;
    s   = hs0 ^ ci;
    hc1 = hs0 & ci;
    co  = hc0 | hc1;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock through serial_fa_cell, registered carry.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH-1:0] load_b;
  logic             load_c;
  logic             accept;
  logic             fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the carry-in, ignoring cin.
  always_comb begin
    load_b = sub ? ~b : b;
    load_c = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    load_b = b;
    load_c = cin;
  end
`endif

  always_comb begin
    accept = start && ((state_q == StIdle) || (state_q == StDone));
  end

  serial_fa_cell u_fa (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // sum/cout are left alone so the previous result stays visible until it is overwritten.
        state_q <= StShift;
        sa_q    <= a;
        sb_q    <= load_b;
        carry_q <= load_c;
        cnt_q   <= '0;
        busy    <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StIdle;
          end
          StShift: begin
            sa_q    <= sa_q >> 1;
            sb_q    <= sb_q >> 1;
            sum     <= {fa_s, sum[WIDTH-1:1]};
            carry_q <= fa_co;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LastBit) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              cout    <= fa_co;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder. It loads two operands on a start pulse, adds one bit per clock through a single-bit full-adder cell with a registered carry, and presents the sum and carry-out with a one-cycle done pulse. It sits directly downstream of the team's combinational half-adder primitives: two half adders form its per-bit cell. It trades WIDTH+1 cycles of latency for a one-bit datapath.

## Interface
- WIDTH, 8: operand and sum width in bits; must be at least 2.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst_n  input  1  reset, synchronous and active-low. Sampled on the rising edge of clk.
- start  input  1  request strobe. Accepted only in IDLE or DONE.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- cin  input  1  carry-in, sampled on the accepting edge.
- sub  input  1  subtract select, sampled on the accepting edge. Port exists only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result. Held from done until the next accepted start.
- cout  output  1  final carry-out. Held with sum.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load shift registers sa=a, sb=b, carry=cin, bit counter=0; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, each edge:
  - Compute s = sa[0]^sb[0]^carry and c = majority(sa[0], sb[0], carry).
  - sa and sb shift right by one.
  - sum shifts right with s entering the MSB.
  - carry becomes c; counter increments.
  - When counter reaches WIDTH-1 on this edge, go to DONE and set cout=c.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 → reload exactly as in IDLE and go to SHIFT (back-to-back operation).
  - start=0 → go to IDLE.
- start is ignored in SHIFT. The operation in progress is unaffected.
- Arithmetic is modulo 2^WIDTH. {cout, sum} = a + b + cin.
- sum and cout are not cleared by start. They change bit by bit during SHIFT and are valid only while done=1 and afterwards in IDLE.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0.
- rst_n=0 in any state, including mid-SHIFT, forces the reset values on that edge. The partial operation is discarded and done is not produced.
- start sampled at edge E0:
  - busy=1 from after E0 through after edge E0+WIDTH-1.
  - After edge E0+WIDTH: busy=0 and done=1.
- Latency from accepting edge to done is WIDTH+1 edges. Minimum start-to-start interval is WIDTH+1 cycles.
- busy and done are never high at the same time.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port is present.
  - With sub=1 at the accepting edge: sb is loaded with ~b, carry is loaded with 1, and cin is ignored, giving sum = a - b.
  - In subtract mode cout=1 means no borrow (a ≥ b unsigned).
  - With sub=0 the behaviour is identical to addition.
- SERIAL_ADDER_SUB_EN undefined:
  - The sub port and its inversion logic are absent.
  - The block always adds.

## Structure
- Shared package/include serial_adder_pkg holds:
  - State encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH.
  - Counter width as clog2(WIDTH).
- One combinational sub-module, serial_fa_cell (inputs x, y, ci; outputs s, co), built from two half-adder stages plus an OR of their carries.
- Top level holds the FSM, the shift registers, the carry flip-flop and the counter.

## Test plan
- WIDTH=8; a=8'h0F, b=8'h01, cin=0 → sum=8'h10, cout=0. done exactly 9 edges after start; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=0, b=0, cin=1 → sum=8'h01, cout=0.
- start reasserted with a=8'hAA during SHIFT → ignored. The first result is unchanged and done is not delayed.
- rst_n=0 at the 4th SHIFT edge → after that edge busy=0, done=0, sum=0, cout=0, state IDLE. No done pulse follows.
- start held high in DONE with a=8'h80, b=8'h80 → immediate reload. The next done arrives 9 edges later with sum=8'h00, cout=1.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0.
  - sub=1, a=8'h07, b=8'h05 → sum=8'h02, cout=1.
